pc_module: RTL and testbench
============================

PC_MODULE -- requirements
Module: pc_module

Interface
REQ-001 Parameter XLEN, default 32, width in bits of PC_Next and PC.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, value loaded into PC on reset.
REQ-003 Parameter FORCE_ALIGN, default 0; when 1, PC bits [1:0] are always stored as 0.
REQ-004 clk  input  1  single clock; all state updates on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high; 1 = reset asserted.
REQ-006 PC_Next  input  XLEN  next program-counter value from next-PC logic (PC+4, branch or jump target).
REQ-007 PC  output  XLEN  current program counter, driven directly from a register, no combinational path from any input.

Function
REQ-008 The module SHALL hold one XLEN-bit PC register, the only state in the block.
REQ-009 On each rising clk edge with rst=1, the PC register SHALL load RESET_VECTOR, regardless of PC_Next.
REQ-010 On each rising clk edge with rst=0, the PC register SHALL load PC_Next (bits [1:0] cleared when FORCE_ALIGN=1).
REQ-011 Latency SHALL be exactly one cycle: PC_Next sampled at edge N appears on PC immediately after edge N.
REQ-012 Between rising edges, PC SHALL stay stable regardless of changes on PC_Next or rst.
REQ-013 No handshake, enable or stall exists; the register updates on every edge.
REQ-014 Loads SHALL be bit-exact with no arithmetic or wrap logic; 32'hFFFF_FFFC and 32'hFFFF_FFFF (FORCE_ALIGN=0) load unchanged.
REQ-015 If rst and any PC_Next value coincide at an edge, reset SHALL win.
REQ-016 Asserting rst mid-operation SHALL take effect at the next rising edge; the following edge with rst=0 loads PC_Next normally.
REQ-017 X/Z on PC_Next while rst=1 SHALL NOT propagate into PC.

Reset
REQ-018 Reset SHALL be synchronous: asserting rst alone, without a rising clk edge, SHALL NOT change PC.
REQ-019 Reset value of PC SHALL be RESET_VECTOR, default 32'h0000_0000.
REQ-020 Before the first reset edge, PC is undefined; users SHALL hold rst=1 for at least one rising edge at start-up.

Structure
REQ-021 XLEN and the default RESET_VECTOR SHALL be defined in the shared core package and used as this module's parameter defaults.
REQ-022 No sub-module SHALL be used: one sequential process plus the optional alignment mask.

Verification
REQ-023 rst=1, PC_Next=32'hDEADBEEF, one rising edge -> PC=32'h0000_0000.
REQ-024 rst=0, PC_Next=32'd4, one rising edge -> PC=32'h0000_0004; then PC_Next=32'd8, next edge -> PC=32'h0000_0008.
REQ-025 rst=0, PC=8, change PC_Next to 32'd12 mid-cycle -> PC stays 8 until the next rising edge, then becomes 12.
REQ-026 PC=8, rst=1 with PC_Next=32'd12 -> PC=32'h0000_0000 after the next edge; rst=0 with PC_Next=32'd16 -> PC=16 after the following edge.
REQ-027 rst pulsed high and low entirely between two edges -> PC unchanged.
REQ-028 RESET_VECTOR=32'h8000_0000, FORCE_ALIGN=1: reset edge -> PC=32'h8000_0000; PC_Next=32'h0000_0107 -> PC=32'h0000_0104.

Source files
------------

// File: rtl/pc_module_pkg.sv
// -----------------------------------------------------------------------------
// pc_module_pkg
// Shared core package: architectural width and the default reset vector used
// as parameter defaults by the program-counter register and other core blocks.
// -----------------------------------------------------------------------------
package pc_module_pkg;

  // Architectural register width of the core.
  localparam int CORE_XLEN = 32;

  // Address the core starts fetching from after reset.
  localparam logic [CORE_XLEN-1:0] CORE_RESET_VECTOR = 32'h0000_0000;

  // Width of the low-order address bits that must be zero for word-aligned fetch.
  localparam int ALIGN_BITS = 2;

endpackage : pc_module_pkg

// File: rtl/pc_module.sv
// -----------------------------------------------------------------------------
// pc_module
// Program-counter register. On every rising clock edge it loads either the
// reset vector (rst=1) or the value offered by the next-PC logic (rst=0).
// There is no enable or stall, and loads are bit-exact. The only exception is
// FORCE_ALIGN=1, where the two low bits are forced to zero.
//
// Parameters
//   XLEN         register width (default from core package)
//   RESET_VECTOR value loaded while rst is high
//   FORCE_ALIGN  1 = store PC with bits [1:0] cleared
//
// Ports
//   clk      in   1     clock, rising-edge active
//   rst      in   1     synchronous active-high reset
//   PC_Next  in   XLEN  next program-counter value
//   PC       out  XLEN  current program counter (straight from the register)
// -----------------------------------------------------------------------------
module pc_module
  import pc_module_pkg::*;
#(
  parameter int              XLEN         = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(CORE_RESET_VECTOR),
  parameter bit              FORCE_ALIGN  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_Next,
  output logic [XLEN-1:0] PC
);

  // The mask is all ones when alignment is off, so the load stays bit-exact.
  localparam logic [XLEN-1:0] ALIGN_MASK =
    FORCE_ALIGN ? ~XLEN'((1 << ALIGN_BITS) - 1) : {XLEN{1'b1}};

  logic [XLEN-1:0] pc_q;

  // Reset takes priority over PC_Next. This ensures that X/Z on PC_Next
  // during reset can never reach the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR & ALIGN_MASK;
    end else begin
      pc_q <= PC_Next & ALIGN_MASK;
    end
  end

  assign PC = pc_q;

endmodule : pc_module

// File: tb/tb_pc_module.sv
// -----------------------------------------------------------------------------
// tb_pc_module
// Directed bench for pc_module. It drives two instances in parallel: the
// default configuration, and a variant with RESET_VECTOR=0x8000_0000 and
// FORCE_ALIGN=1. Both instances share clk, rst and PC_Next.
// -----------------------------------------------------------------------------
module tb_pc_module;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic [31:0] pc_def;
  logic [31:0] pc_aln;

  int compared   = 0;
  int mismatched = 0;

  pc_module dut_def (
    .clk     (clk),
    .rst     (rst),
    .PC_Next (pc_next),
    .PC      (pc_def)
  );

  pc_module #(
    .XLEN         (32),
    .RESET_VECTOR (32'h8000_0000),
    .FORCE_ALIGN  (1'b1)
  ) dut_aln (
    .clk     (clk),
    .rst     (rst),
    .PC_Next (pc_next),
    .PC      (pc_aln)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Set the inputs, then move to 2 time units after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [31:0] n);
    rst     = r;
    pc_next = n;
    @(posedge clk);
    #2;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    pc_next = 32'hDEAD_BEEF;

    // Reset must win over a garbage PC_Next.
    applyStimulus(1'b1, 32'hDEAD_BEEF);
    checkOutput("reset_def", pc_def, 32'h0000_0000);
    checkOutput("reset_aln", pc_aln, 32'h8000_0000);

    // Sequential loads with one-cycle latency.
    applyStimulus(1'b0, 32'd4);
    checkOutput("load4_def", pc_def, 32'h0000_0004);
    checkOutput("load4_aln", pc_aln, 32'h0000_0004);
    applyStimulus(1'b0, 32'd8);
    checkOutput("load8_def", pc_def, 32'h0000_0008);

    // A mid-cycle change on PC_Next must not show up before the edge.
    pc_next = 32'd12;
    #1;
    checkOutput("midcycle_hold", pc_def, 32'h0000_0008);
    @(posedge clk);
    #2;
    checkOutput("midcycle_load", pc_def, 32'h0000_000C);

    // Reset in the middle of operation, then resume loading.
    applyStimulus(1'b0, 32'd8);
    checkOutput("reload8", pc_def, 32'h0000_0008);
    applyStimulus(1'b1, 32'd12);
    checkOutput("midreset_def", pc_def, 32'h0000_0000);
    checkOutput("midreset_aln", pc_aln, 32'h8000_0000);
    applyStimulus(1'b0, 32'd16);
    checkOutput("resume16", pc_def, 32'h0000_0010);

    // Pulse rst entirely between two edges. Change PC_Next too; PC must hold.
    rst     = 1'b1;
    pc_next = 32'd99;
    #2;
    rst     = 1'b0;
    #1;
    checkOutput("rst_pulse_def", pc_def, 32'h0000_0010);
    checkOutput("rst_pulse_aln", pc_aln, 32'h0000_0010);

    // Top-of-range values load unchanged; the aligned copy clears bits [1:0].
    applyStimulus(1'b0, 32'hFFFF_FFFC);
    checkOutput("fffc_def", pc_def, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    checkOutput("ffff_def", pc_def, 32'hFFFF_FFFF);
    checkOutput("ffff_aln", pc_aln, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0000_0107);
    checkOutput("unaligned_def", pc_def, 32'h0000_0107);
    checkOutput("unaligned_aln", pc_aln, 32'h0000_0104);

    // X on PC_Next during reset must not reach PC.
    applyStimulus(1'b1, 32'hxxxx_xxxx);
    checkOutput("xreset_def", pc_def, 32'h0000_0000);
    checkOutput("xreset_aln", pc_aln, 32'h8000_0000);
    applyStimulus(1'b0, 32'd20);
    checkOutput("after_x_def", pc_def, 32'h0000_0014);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pc_module
